// File: rtl/bank_readout_scheduler_pkg.sv
// Shared definitions for the ping-pong bank readout scheduler: reader FSM
// state codes and default geometry, used by the RTL and its bench alike.
package bank_readout_scheduler_pkg;

    localparam int DEF_WORD_W  = 7;
    localparam int DEF_N_WORDS = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_FETCH   = 3'd2,
        ST_LOAD    = 3'd3,
        ST_SHIFT   = 3'd4,
        ST_DONE    = 3'd5
    } readoutState_e;

endpackage

// File: rtl/bank_readout_scheduler_shifter.sv
// Parallel-load, MSB-first shift register with a bit counter; lastBit_o
// marks that the next shift consumes the final bit of the word.
module readout_shifter
    import bank_readout_scheduler_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              msb_o,
    output logic              lastBit_o
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] shiftReg_q;
    logic [CNT_W-1:0]  bitCnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shiftReg_q <= '0;
            bitCnt_q   <= '0;
        end else if (load_i) begin
            shiftReg_q <= data_i;
            bitCnt_q   <= '0;
        end else if (shift_i) begin
            shiftReg_q <= shiftReg_q << 1;
            bitCnt_q   <= bitCnt_q + CNT_W'(1);
        end
    end

    assign msb_o     = shiftReg_q[WORD_W-1];
    assign lastBit_o = (bitCnt_q == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/bank_readout_scheduler.sv
// Ping-pong bank controller: tracks writer/reader banks, swaps on frame
// completion, counts overruns and sequences the serial readout of a full bank.
module bank_readout_scheduler
    import bank_readout_scheduler_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int N_WORDS = DEF_N_WORDS,
    parameter int ADDR_W  = 4,
    parameter int OVR_W   = 8
) (
    input  logic              input_acquisition_clk,
    input  logic              reset,
    input  logic              frame_done,
    input  logic              readout_req,
    input  logic              bit_tick,
    input  logic [WORD_W-1:0] rd_data,
    output logic              write_bank,
    output logic              read_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [2:0]        state_reg_FSM,
    output logic              sending_pending,
    output logic              sending_started,
    output logic              sending_data,
    output logic              serial_out,
    output logic [OVR_W-1:0]  overrun_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

    readoutState_e     state_q, stateD;
    logic              writeBank_q, writeBankD;
    logic              readBank_q, readBankD;
    logic [1:0]        full_q, fullD, fullAfterDone;
    logic [ADDR_W-1:0] rdAddr_q, rdAddrD;
    logic [OVR_W-1:0]  overrunCnt_q, overrunD;
    logic              sendingPending_q, sendingStarted_q, sendingData_q;
    logic              startD, loadShift, doShift;
    logic              shiftMsb, lastBit;

    // A bank released by DONE is already free for a frame finishing this cycle.
    always_comb begin
        fullAfterDone = full_q;
        if (state_q == ST_DONE) fullAfterDone[readBank_q] = 1'b0;
        fullD      = fullAfterDone;
        writeBankD = writeBank_q;
        overrunD   = overrunCnt_q;
        if (frame_done) begin
            fullD[writeBank_q] = 1'b1;
            if (!fullAfterDone[~writeBank_q]) writeBankD = ~writeBank_q;
            else if (overrunCnt_q != '1)      overrunD   = overrunCnt_q + OVR_W'(1);
        end
    end

    always_comb begin
        stateD    = state_q;
        rdAddrD   = rdAddr_q;
        readBankD = readBank_q;
        startD    = 1'b0;
        loadShift = 1'b0;
        doShift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[~writeBank_q]) begin
                    readBankD = ~writeBank_q;
                    rdAddrD   = '0;
                    stateD    = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (readout_req) begin
                    startD = 1'b1;
                    stateD = ST_FETCH;
                end
            end
            ST_FETCH: stateD = ST_LOAD;
            ST_LOAD: begin
                loadShift = 1'b1;
                stateD    = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_tick) begin
                    doShift = 1'b1;
                    if (lastBit) begin
                        if (rdAddr_q == LAST_ADDR) begin
                            stateD = ST_DONE;
                        end else begin
                            rdAddrD = rdAddr_q + ADDR_W'(1);
                            stateD  = ST_FETCH;
                        end
                    end
                end
            end
            ST_DONE: stateD = ST_IDLE;
            default: stateD = ST_IDLE;
        endcase
    end

    always_ff @(posedge input_acquisition_clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            writeBank_q      <= 1'b0;
            readBank_q       <= 1'b1;
            full_q           <= 2'b00;
            rdAddr_q         <= '0;
            overrunCnt_q     <= '0;
            sendingPending_q <= 1'b0;
            sendingStarted_q <= 1'b0;
            sendingData_q    <= 1'b0;
        end else begin
            state_q          <= stateD;
            writeBank_q      <= writeBankD;
            readBank_q       <= readBankD;
            full_q           <= fullD;
            rdAddr_q         <= rdAddrD;
            overrunCnt_q     <= overrunD;
            sendingPending_q <= (stateD == ST_PENDING);
            sendingStarted_q <= startD;
            sendingData_q    <= (stateD == ST_FETCH) || (stateD == ST_LOAD) ||
                                (stateD == ST_SHIFT) || (stateD == ST_DONE);
        end
    end

    readout_shifter #(.WORD_W(WORD_W)) uShifter (
        .clk_i     (input_acquisition_clk),
        .reset_i   (reset),
        .load_i    (loadShift),
        .shift_i   (doShift),
        .data_i    (rd_data),
        .msb_o     (shiftMsb),
        .lastBit_o (lastBit)
    );

    assign write_bank      = writeBank_q;
    assign read_bank       = readBank_q;
    assign rd_addr         = rdAddr_q;
    assign state_reg_FSM   = state_q;
    assign sending_pending = sendingPending_q;
    assign sending_started = sendingStarted_q;
    assign sending_data    = sendingData_q;
    assign serial_out      = (state_q == ST_SHIFT) && shiftMsb;
    assign overrun_cnt     = overrunCnt_q;

endmodule

// File: tb/tb_bank_readout_scheduler.sv
// Directed bench for bank_readout_scheduler: bank swapping, handshake, serial
// readout, overrun saturation, DONE/frame_done collision and mid-transfer reset.
module tb_bank_readout_scheduler;
    import bank_readout_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       reset, frame_done, readout_req, bit_tick;
    logic [6:0] rd_data = '0;
    logic [6:0] mem [16];

    logic       write_bank, read_bank, sending_pending, sending_started, sending_data, serial_out;
    logic [3:0] rd_addr;
    logic [2:0] state_reg_FSM;
    logic [7:0] overrun_cnt;

    logic       wb2, rb2, pend2, start2, data2, ser2;
    logic [3:0] addr2;
    logic [2:0] st2;
    logic [1:0] ovr2;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Registered bank memory: data for an address appears one cycle later.
    always @(posedge clk) rd_data <= mem[rd_addr];

    bank_readout_scheduler #(.WORD_W(7), .N_WORDS(16), .ADDR_W(4), .OVR_W(8)) dut (
        .input_acquisition_clk(clk), .reset(reset), .frame_done(frame_done),
        .readout_req(readout_req), .bit_tick(bit_tick), .rd_data(rd_data),
        .write_bank(write_bank), .read_bank(read_bank), .rd_addr(rd_addr),
        .state_reg_FSM(state_reg_FSM), .sending_pending(sending_pending),
        .sending_started(sending_started), .sending_data(sending_data),
        .serial_out(serial_out), .overrun_cnt(overrun_cnt)
    );

    bank_readout_scheduler #(.WORD_W(7), .N_WORDS(16), .ADDR_W(4), .OVR_W(2)) dut2 (
        .input_acquisition_clk(clk), .reset(reset), .frame_done(frame_done),
        .readout_req(readout_req), .bit_tick(bit_tick), .rd_data(rd_data),
        .write_bank(wb2), .read_bank(rb2), .rd_addr(addr2),
        .state_reg_FSM(st2), .sending_pending(pend2),
        .sending_started(start2), .sending_data(data2),
        .serial_out(ser2), .overrun_cnt(ovr2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fd, input logic tick);
        frame_done = fd;
        bit_tick   = tick;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
        bit_tick   = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rstWriteBank", write_bank, 1'b0);
        checkOutput("rstReadBank", read_bank, 1'b1);
        checkOutput("rstAddr", rd_addr, 4'd0);
        checkOutput("rstState", state_reg_FSM, ST_IDLE);
        checkOutput("rstPending", sending_pending, 1'b0);
        checkOutput("rstStarted", sending_started, 1'b0);
        checkOutput("rstData", sending_data, 1'b0);
        checkOutput("rstSerial", serial_out, 1'b0);
        checkOutput("rstOverrun", overrun_cnt, 8'd0);
        checkOutput("rstFull", dut.full_q, 2'b00);
    endtask

    task automatic shiftWord(input logic [6:0] w, input int addr, input bit lastWord);
        checkOutput("wordState", state_reg_FSM, ST_SHIFT);
        checkOutput("wordAddr", rd_addr, addr);
        for (int b = 6; b >= 0; b--) begin
            checkOutput("serialBit", serial_out, w[b]);
            applyStimulus(1'b0, 1'b1);
            if (!(lastWord && b == 0)) begin
                applyStimulus(1'b0, 1'b0);
                applyStimulus(1'b0, 1'b0);
            end
        end
    endtask

    task automatic readFrame();
        for (int a = 0; a < 16; a++) shiftWord(mem[a], a, a == 15);
        checkOutput("doneState", state_reg_FSM, ST_DONE);
        checkOutput("doneData", sending_data, 1'b1);
        checkOutput("doneSerial", serial_out, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; frame_done = 1'b0; readout_req = 1'b0; bit_tick = 1'b0;
        for (int a = 0; a < 16; a++) mem[a] = 7'(a);
        mem[0] = 7'h55;

        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkResetState();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Single frame: swap, then reader claims bank 0.
        applyStimulus(1'b1, 1'b0);
        checkOutput("f1WriteBank", write_bank, 1'b1);
        checkOutput("f1Full", dut.full_q, 2'b01);
        checkOutput("f1StateIdle", state_reg_FSM, ST_IDLE);
        applyStimulus(1'b0, 1'b0);
        checkOutput("f1StatePend", state_reg_FSM, ST_PENDING);
        checkOutput("f1ReadBank", read_bank, 1'b0);
        checkOutput("f1Pending", sending_pending, 1'b1);
        checkOutput("f1DataIdle", sending_data, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("pendTickIgnored", state_reg_FSM, ST_PENDING);

        readout_req = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("hsFetch", state_reg_FSM, ST_FETCH);
        checkOutput("hsStarted", sending_started, 1'b1);
        checkOutput("hsPendingLow", sending_pending, 1'b0);
        checkOutput("hsData", sending_data, 1'b1);
        readout_req = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("hsLoad", state_reg_FSM, ST_LOAD);
        checkOutput("hsStartedOnce", sending_started, 1'b0);
        checkOutput("loadSerial", serial_out, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        readFrame();
        applyStimulus(1'b0, 1'b0);
        checkOutput("endState", state_reg_FSM, ST_IDLE);
        checkOutput("endFull", dut.full_q, 2'b00);
        checkOutput("endData", sending_data, 1'b0);
        checkOutput("endWriteBank", write_bank, 1'b1);

        // Overrun: six frames with the host not ready.
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("ov1WriteBank", write_bank, 1'b1);
        checkOutput("ov1Count", overrun_cnt, 8'd0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ov2WriteBank", write_bank, 1'b1);
        checkOutput("ov2Count", overrun_cnt, 8'd1);
        checkOutput("ov2Full", dut.full_q, 2'b11);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ov3WriteBank", write_bank, 1'b1);
        checkOutput("ov3Count", overrun_cnt, 8'd2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ov4Count", overrun_cnt, 8'd3);
        checkOutput("ov4Sat", ovr2, 2'd3);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ov6Count", overrun_cnt, 8'd5);
        checkOutput("ov6Sat", ovr2, 2'd3);
        checkOutput("ovState", state_reg_FSM, ST_PENDING);
        checkOutput("ovReadBank", read_bank, 1'b0);

        // Drain bank 0 while a new frame lands exactly in DONE.
        mem[0] = 7'h00;
        readout_req = 1'b1;
        applyStimulus(1'b0, 1'b0);
        readout_req = 1'b0;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        readFrame();
        applyStimulus(1'b1, 1'b0);
        checkOutput("simState", state_reg_FSM, ST_IDLE);
        checkOutput("simWriteBank", write_bank, 1'b0);
        checkOutput("simOverrun", overrun_cnt, 8'd5);
        checkOutput("simFull", dut.full_q, 2'b10);
        applyStimulus(1'b0, 1'b0);
        checkOutput("simPending", state_reg_FSM, ST_PENDING);
        checkOutput("simReadBank", read_bank, 1'b1);

        // Reset in the middle of shifting word 0 of bank 1.
        mem[0] = 7'h55;
        readout_req = 1'b1;
        applyStimulus(1'b0, 1'b0);
        readout_req = 1'b0;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rsMsb", serial_out, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rsBit1", serial_out, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("rsBit2", serial_out, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkResetState();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("rsRestartWb", write_bank, 1'b1);
        checkOutput("rsRestartFull", dut.full_q, 2'b01);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rsRestartState", state_reg_FSM, ST_PENDING);
        checkOutput("rsRestartRb", read_bank, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bank_readout_scheduler.md
Name: bank_readout_scheduler

Overview:
- Ping-pong memory controller between acquisition and serial readout.
- Tracks which of two sample banks the acquisition path writes and which the readout path drains.
- Swaps banks on frame completion and flags overruns.
- Sequences the serial readout of the full bank: pending/start handshake, word fetch, MSB-first bit shifting.

Parameters:
- WORD_W, 7, bits per stored sample word (ch1 width).
- N_WORDS, 16, words per bank frame.
- ADDR_W, 4, read address width; requires 2**ADDR_W >= N_WORDS.
- OVR_W, 8, overrun counter width.

Ports:
- input_acquisition_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- frame_done  in  1  one-cycle pulse: writer finished filling write_bank.
- readout_req  in  1  level: host ready to receive.
- bit_tick  in  1  one-cycle strobe per serial bit (already synchronised).
- rd_data  in  WORD_W  bank memory read data; registered memory, valid 1 cycle after rd_addr.
- write_bank  out  1  bank selected for acquisition writes.
- read_bank  out  1  bank selected for readout.
- rd_addr  out  ADDR_W  read word address.
- state_reg_FSM  out  3  current readout state encoding.
- sending_pending  out  1  full bank waiting for host.
- sending_started  out  1  one-cycle pulse at readout start.
- sending_data  out  1  readout transfer in progress.
- serial_out  out  1  serial data bit.
- overrun_cnt  out  OVR_W  saturating count of frames written with no free bank.

Behaviour:
- Reset values: write_bank=0, read_bank=1, full[1:0]=00, rd_addr=0, state=IDLE, shift register=0, bit count=0, overrun_cnt=0. All pulse and level outputs are 0.
- State encoding: IDLE=0, PENDING=1, FETCH=2, LOAD=3, SHIFT=4, DONE=5. Codes 6 and 7 go to IDLE on the next cycle.
- All outputs are registered or decoded from registered state only.

Bank logic, evaluated in order each cycle:
- (a) DONE state clears full[read_bank].
- (b) On frame_done, full[write_bank] is set.
  - If full[~write_bank] is 0 after step (a), write_bank toggles.
  - Otherwise write_bank holds (next frame overwrites) and overrun_cnt increments, saturating at all-ones.
- DONE coinciding with frame_done therefore swaps without overrun.
- write_bank never equals read_bank while state is not IDLE.

Reader FSM:
- IDLE: if full[~write_bank], load read_bank<=~write_bank, rd_addr<=0, and go to PENDING.
- PENDING: sending_pending=1.
  - When readout_req=1, go to FETCH and pulse sending_started for exactly that transition cycle.
- FETCH: rd_addr is stable; wait 1 cycle for memory latency; go to LOAD.
- LOAD: shift register <= rd_data; bit count <= 0; go to SHIFT.
- SHIFT: serial_out = shift register MSB.
  - On each bit_tick: shift left and increment bit count.
  - On the WORD_W-th tick: if rd_addr==N_WORDS-1 go to DONE, else rd_addr++ and go to FETCH.
- DONE: 1 cycle, releases the bank, returns to IDLE.
- sending_data=1 in FETCH, LOAD, SHIFT and DONE.
- serial_out=0 outside SHIFT.
- bit_tick in any state other than SHIFT is ignored. The host guarantees tick spacing of at least 3 cycles.
- readout_req dropping after PENDING does not abort the transfer.
- Reset mid-transfer abandons the frame. Both banks are marked empty.

Decomposition:
- Shared package holds the FSM state localparams (IDLE..DONE, 3-bit) and default WORD_W/N_WORDS, so the top level and the bench decode state_reg_FSM identically.
- One natural sub-module: readout_shifter (parallel load, MSB-first shift, bit counter, last_bit flag).
- Bank bookkeeping and the FSM stay in the parent.

Test Plan:
- Reset then single frame (WORD_W=7, N_WORDS=16):
  - frame_done pulse -> next cycle write_bank=1, full={0,1}.
  - Following cycle state=PENDING and read_bank=0; sending_pending=1.
- Handshake: readout_req=1 in PENDING -> sending_started high exactly one cycle; state 1->2->3.
  - With rd_data=7'h55 at rd_addr=0, serial_out sequence is 1,0,1,0,1,0,1 over 7 bit_ticks.
- Full frame of 16 words with rd_data=rd_addr pattern -> 112 bits match the pattern MSB-first.
  - DONE lasts 1 cycle, then full[0]=0, state=IDLE, sending_data=0.
- Overrun: three frame_done pulses while readout_req=0 -> write_bank stays 1 after the second pulse.
  - overrun_cnt=1 after the 2nd pulse and 2 after the 3rd.
  - With OVR_W=2, six pulses hold the count saturated at 3.
- Simultaneous: frame_done in the same cycle as DONE -> write_bank toggles and overrun_cnt is unchanged.
  - Next cycle the reader enters PENDING on the other bank.
- Reset asserted during SHIFT -> next cycle all outputs at reset values, full=00.
  - A subsequent frame_done restarts cleanly.
  - bit_tick during FETCH/LOAD never shifts.
